// File: rtl/lcd_8080_capture.sv
// lcd_8080_capture: captures an 8080-style LCD write bus into framebuffer pixel/command strobes.
// Define LCD_CAPTURE_RAMWRC_EN to accept 0x3C (memory write continue).
module lcd_8080_capture #(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        LCD_CS,
    input  logic        LCD_RS,
    input  logic        LCD_WR,
    input  logic        LCD_RD,
    input  logic        LCD_RST,
    input  logic [15:0] LCD_DATA,
    output logic        PIX_VALID,
    output logic [16:0] PIX_ADDR,
    output logic [15:0] PIX_DATA,
    output logic        CMD_VALID,
    output logic [7:0]  CMD_CODE,
    output logic        WIN_ERR
);
`ifdef LCD_CAPTURE_RAMWRC_EN
    localparam bit RAMWRC = 1'b1;
`else
    localparam bit RAMWRC = 1'b0;
`endif
    localparam logic [15:0] HMAX  = 16'(H_RES - 1);
    localparam logic [15:0] VMAX  = 16'(V_RES - 1);
    localparam logic [16:0] HSTEP = 17'(H_RES);

    typedef enum logic [1:0] {IDLE, CASET, PASET, RAMWR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cs_q, rs_q, wr_q, rst_q;
    logic        wr_prev_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] par_q, par_d;
    logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0] cx_q, cx_d, cy_q, cy_d;
    logic [16:0] addr_q, addr_d, row_q, row_d, base_q, base_d;
    logic        drop_q, drop_d;
    logic        pix_valid_q, pix_valid_d;
    logic [16:0] pix_addr_q, pix_addr_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic        win_err_q, win_err_d;
    logic        rst_all, strobe, is_cmd, is_dat, bad_win;
    logic [7:0]  bus_byte;
    logic [16:0] start_addr;
    logic        unused_rd;

    assign unused_rd  = LCD_RD;
    assign rst_all    = HRESET | ~rst_q[1];
    assign strobe     = wr_q[1] & ~wr_prev_q & ~cs_q[1];
    assign is_cmd     = strobe & ~rs_q[1];
    assign is_dat     = strobe & rs_q[1];
    assign bus_byte   = LCD_DATA[7:0];
    assign bad_win    = (sc_q > ec_q) || (ec_q > HMAX) || (sp_q > ep_q) || (ep_q > VMAX);
    // Constant-coefficient product, evaluated only once per frame start; per-pixel stepping is additive.
    assign start_addr = 17'(sp_q) * HSTEP + 17'(sc_q);

    // The panel-reset synchronizer only answers to HRESET, otherwise it would hold itself in reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) rst_q <= 2'b11;
        else rst_q <= {rst_q[0], LCD_RST};
    end

    always_ff @(posedge HCLK) begin
        if (rst_all) begin
            cs_q      <= 2'b11;
            rs_q      <= 2'b00;
            wr_q      <= 2'b11;
            wr_prev_q <= 1'b1;
        end else begin
            cs_q      <= {cs_q[0], LCD_CS};
            rs_q      <= {rs_q[0], LCD_RS};
            wr_q      <= {wr_q[0], LCD_WR};
            wr_prev_q <= wr_q[1];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        sc_d        = sc_q;
        ec_d        = ec_q;
        sp_d        = sp_q;
        ep_d        = ep_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        addr_d      = addr_q;
        row_d       = row_q;
        base_d      = base_q;
        drop_d      = drop_q;
        pix_valid_d = 1'b0;
        pix_addr_d  = pix_addr_q;
        pix_data_d  = pix_data_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        win_err_d   = win_err_q;
        if (is_cmd) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = bus_byte;
            cnt_d       = 2'd0;
            state_d     = bus_byte == 8'h2A ? CASET :
                          bus_byte == 8'h2B ? PASET :
                          (bus_byte == 8'h2C || (RAMWRC && bus_byte == 8'h3C)) ? RAMWR : IDLE;
            if (bus_byte == 8'h01) begin
                sc_d = 16'd0;
                ec_d = HMAX;
                sp_d = 16'd0;
                ep_d = VMAX;
            end
            if (bus_byte == 8'h2C) begin
                cx_d      = sc_q;
                cy_d      = sp_q;
                base_d    = start_addr;
                row_d     = start_addr;
                addr_d    = start_addr;
                drop_d    = bad_win;
                win_err_d = win_err_q | bad_win;
            end
        end else if (is_dat) begin
            if (state_q == CASET || state_q == PASET) begin
                cnt_d = cnt_q + 2'd1;
                par_d = {par_q[15:0], bus_byte};
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                    if (state_q == CASET) begin
                        sc_d = par_q[23:8];
                        ec_d = {par_q[7:0], bus_byte};
                    end else begin
                        sp_d = par_q[23:8];
                        ep_d = {par_q[7:0], bus_byte};
                    end
                end
            end else if (state_q == RAMWR && !drop_q) begin
                pix_valid_d = 1'b1;
                pix_addr_d  = addr_q;
                pix_data_d  = LCD_DATA;
                if (cx_q != ec_q) begin
                    cx_d   = cx_q + 16'd1;
                    addr_d = addr_q + 17'd1;
                end else if (cy_q != ep_q) begin
                    cx_d   = sc_q;
                    cy_d   = cy_q + 16'd1;
                    row_d  = row_q + HSTEP;
                    addr_d = row_q + HSTEP;
                end else begin
                    cx_d   = sc_q;
                    cy_d   = sp_q;
                    row_d  = base_q;
                    addr_d = base_q;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (rst_all) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            par_q       <= 24'd0;
            sc_q        <= 16'd0;
            ec_q        <= HMAX;
            sp_q        <= 16'd0;
            ep_q        <= VMAX;
            cx_q        <= 16'd0;
            cy_q        <= 16'd0;
            addr_q      <= 17'd0;
            row_q       <= 17'd0;
            base_q      <= 17'd0;
            drop_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_addr_q  <= 17'd0;
            pix_data_q  <= 16'd0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 8'd0;
            win_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            sc_q        <= sc_d;
            ec_q        <= ec_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            addr_q      <= addr_d;
            row_q       <= row_d;
            base_q      <= base_d;
            drop_q      <= drop_d;
            pix_valid_q <= pix_valid_d;
            pix_addr_q  <= pix_addr_d;
            pix_data_q  <= pix_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            win_err_q   <= win_err_d;
        end
    end

    assign PIX_VALID = pix_valid_q;
    assign PIX_ADDR  = pix_addr_q;
    assign PIX_DATA  = pix_data_q;
    assign CMD_VALID = cmd_valid_q;
    assign CMD_CODE  = cmd_code_q;
    assign WIN_ERR   = win_err_q;
endmodule

// File: tb/tb_lcd_8080_capture.sv
// tb_lcd_8080_capture: directed bus transactions against hand-computed pixel addresses and flags.
module tb_lcd_8080_capture;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        LCD_CS = 1'b1;
    logic        LCD_RS = 1'b0;
    logic        LCD_WR = 1'b1;
    logic        LCD_RD = 1'b1;
    logic        LCD_RST = 1'b1;
    logic [15:0] LCD_DATA = 16'd0;
    logic        PIX_VALID;
    logic [16:0] PIX_ADDR;
    logic [15:0] PIX_DATA;
    logic        CMD_VALID;
    logic [7:0]  CMD_CODE;
    logic        WIN_ERR;
    int          checks = 0;
    int          errors = 0;
    int          pcnt = 0;
    int          ccnt = 0;
    logic [16:0] last_addr = 17'd0;
    logic [15:0] last_data = 16'd0;

    lcd_8080_capture dut (
        .HCLK(HCLK), .HRESET(HRESET), .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR),
        .LCD_RD(LCD_RD), .LCD_RST(LCD_RST), .LCD_DATA(LCD_DATA), .PIX_VALID(PIX_VALID),
        .PIX_ADDR(PIX_ADDR), .PIX_DATA(PIX_DATA), .CMD_VALID(CMD_VALID), .CMD_CODE(CMD_CODE),
        .WIN_ERR(WIN_ERR)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (PIX_VALID) begin
            pcnt++;
            last_addr = PIX_ADDR;
            last_data = PIX_DATA;
        end
        if (CMD_VALID) ccnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic rs, input logic [15:0] d);
        @(negedge HCLK);
        LCD_CS = 1'b0;
        LCD_RS = rs;
        LCD_DATA = d;
        LCD_WR = 1'b0;
        repeat (3) @(negedge HCLK);
        LCD_WR = 1'b1;
        repeat (5) @(negedge HCLK);
    endtask

    task automatic cmd(input logic [7:0] c);
        int n;
        n = ccnt;
        wr(1'b0, {8'h00, c});
        chk("cmd_cnt", ccnt, n + 1);
        chk("cmd_code", CMD_CODE, c);
    endtask

    task automatic px(input logic [15:0] d, input logic [16:0] a);
        int n;
        n = pcnt;
        wr(1'b1, d);
        chk("pix_cnt", pcnt, n + 1);
        chk("pix_addr", last_addr, a);
        chk("pix_data", last_data, d);
    endtask

    task automatic nopx(input logic [15:0] d);
        int n;
        n = pcnt;
        wr(1'b1, d);
        chk("no_pix", pcnt, n);
    endtask

    task automatic params(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        cmd(c);
        wr(1'b1, {8'h00, s[15:8]});
        wr(1'b1, {8'h00, s[7:0]});
        wr(1'b1, {8'h00, e[15:8]});
        wr(1'b1, {8'h00, e[7:0]});
    endtask

    task automatic hreset();
        @(negedge HCLK);
        LCD_CS = 1'b1;
        LCD_WR = 1'b1;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        repeat (3) @(negedge HCLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pix_valid"}, PIX_VALID, 0);
        chk({tag, "_pix_addr"}, PIX_ADDR, 0);
        chk({tag, "_pix_data"}, PIX_DATA, 0);
        chk({tag, "_cmd_valid"}, CMD_VALID, 0);
        chk({tag, "_cmd_code"}, CMD_CODE, 0);
        chk({tag, "_win_err"}, WIN_ERR, 0);
    endtask

    initial begin
        int n, m;
        logic [16:0] a32 [7];
        a32 = '{17'd1210, 17'd1211, 17'd1212, 17'd1450, 17'd1451, 17'd1452, 17'd1210};
        hreset();
        chk_reset_outputs("rst");
        // basic full-screen RAMWR
        cmd(8'h2C);
        px(16'hF800, 17'd0);
        px(16'h07E0, 17'd1);
        px(16'h001F, 17'd2);
        chk("win_err_ok", WIN_ERR, 0);
        // 3x2 window with frame wrap
        params(8'h2A, 16'd10, 16'd12);
        params(8'h2B, 16'd5, 16'd6);
        cmd(8'h2C);
        for (int i = 0; i < 7; i++) px(16'h0100 + 16'(i), a32[i]);
        // aborted CASET leaves columns at 0..239
        hreset();
        cmd(8'h2A);
        wr(1'b1, 16'h0000);
        wr(1'b1, 16'h000A);
        params(8'h2B, 16'd1, 16'd1);
        cmd(8'h2C);
        for (int i = 0; i < 240; i++) px(16'(i) ^ 16'hA5A5, 17'd240 + 17'(i));
        px(16'h1234, 17'd240);
        // illegal window
        params(8'h2A, 16'd20, 16'd10);
        cmd(8'h2C);
        chk("win_err_set", WIN_ERR, 1);
        nopx(16'hBEEF);
        nopx(16'hCAFE);
        // 0x01 restores full screen; the flag stays sticky
        cmd(8'h01);
        cmd(8'h2C);
        chk("win_err_sticky", WIN_ERR, 1);
        px(16'h1111, 17'd0);
        // strobes with CS high are ignored
        n = pcnt;
        m = ccnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            LCD_CS = 1'b1;
            LCD_RS = i[0];
            LCD_DATA = 16'h2C2C;
            LCD_WR = 1'b0;
            repeat (3) @(negedge HCLK);
            LCD_WR = 1'b1;
            repeat (5) @(negedge HCLK);
        end
        chk("cs_high_pix", pcnt, n);
        chk("cs_high_cmd", ccnt, m);
        px(16'h2222, 17'd1);
        // panel reset mid-RAMWR
        @(negedge HCLK);
        LCD_CS = 1'b1;
        LCD_RST = 1'b0;
        repeat (5) @(negedge HCLK);
        chk_reset_outputs("lcd_rst");
        LCD_RST = 1'b1;
        repeat (4) @(negedge HCLK);
        chk_reset_outputs("lcd_rst_rel");
        nopx(16'h3333);
        cmd(8'h2C);
        px(16'h4444, 17'd0);
        // memory write continue
        hreset();
        cmd(8'h2C);
        px(16'h0A0A, 17'd0);
        px(16'h0B0B, 17'd1);
        cmd(8'h00);
        nopx(16'h0C0C);
        cmd(8'h3C);
`ifdef LCD_CAPTURE_RAMWRC_EN
        px(16'h0D0D, 17'd2);
`else
        nopx(16'h0D0D);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
